// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART servo command parser:
//   - ASCII constants used by the parser and the optional ack path
//   - parser state encoding
//   - hex character to nibble decode with a validity flag
// No ports (package).
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] ASC_S_UP = 8'h53;  // 'S'
    localparam logic [7:0] ASC_S_LO = 8'h73;  // 's'
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_SP   = 8'h20;
    localparam logic [7:0] ASC_K    = 8'h4B;  // ack: command accepted
    localparam logic [7:0] ASC_E    = 8'h45;  // ack: line rejected
    localparam logic [7:0] ASC_0    = 8'h30;  // '0'

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHAN = 3'd1,
        ST_HEX  = 3'd2,
        ST_TERM = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] nib;
    } hex_t;

    // '0'-'9', 'A'-'F', 'a'-'f' -> nibble; ok=0 for anything else
    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t h;
        h.ok  = 1'b1;
        h.nib = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            h.nib = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // low nibble of 'A'/'a' is 1, so +9 maps it to 10
            h.nib = c[3:0] + 4'd9;
        end else begin
            h.ok = 1'b0;
        end
        return h;
    endfunction

    function automatic logic is_eol(input logic [7:0] c);
        return (c == ASC_CR) || (c == ASC_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// ---------------------------------------------------------------------------
// uart_cmd_timeout
// Saturating inter-byte timer. Cleared by i_clr (priority), counts while
// i_en, stops at TIMEOUT_CYC-1 and reports o_expired while parked there.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        clear counter to 0 (a byte arrived)
//   i_en         count this cycle (parser mid-line)
//   o_expired    counter == TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Parses "S<chan><hex><hex><hex><hex><CR|LF>" servo commands from the UART
// receiver byte stream and emits decoded (channel, 16-bit target) commands.
// Malformed or stalled lines raise a one-cycle cmd_err and are discarded.
// Optional build macro: UART_CMD_ACK_EN adds a one-entry ack byte holding
// register ('K' accepted / 'E' rejected) toward the UART transmitter.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_avail, rx_data    one-cycle byte strobe and byte from the receiver
//   cmd_valid            one-cycle strobe, cmd_chan/cmd_value updated
//   cmd_chan, cmd_value  last accepted command, held between strobes
//   cmd_err              one-cycle strobe, line rejected
//   busy                 a command is partially received
//   ack_valid/ack_data/ack_ready  (UART_CMD_ACK_EN only) ack byte handshake
// ---------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CH_W        = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_avail,
    input  logic [7:0]      rx_data,
    output logic            cmd_valid,
    output logic [CH_W-1:0] cmd_chan,
    output logic [15:0]     cmd_value,
    output logic            cmd_err,
    output logic            busy
`ifdef UART_CMD_ACK_EN
    ,
    output logic            ack_valid,
    output logic [7:0]      ack_data,
    input  logic            ack_ready
`endif
);

    localparam logic [7:0] CH_LIMIT = 8'(48 + NUM_CH);  // first invalid digit

    state_t          r_state;
    state_t          w_state_next;
    logic [CH_W-1:0] r_chan_tmp;
    logic [15:0]     r_value;
    logic [1:0]      r_nib_cnt;
    logic            r_cmd_valid;
    logic            r_cmd_err;
    logic [CH_W-1:0] r_cmd_chan;
    logic [15:0]     r_cmd_value;

    hex_t            w_hex;
    logic            w_eol;
    logic            w_is_s;
    logic            w_chan_ok;
    logic [7:0]      w_digit;
    logic            w_expired;
    logic            w_tmr_en;
    logic            w_timeout;
    logic            w_valid_next;
    logic            w_err_next;
    logic            w_chan_ld;
    logic            w_nib_ld;

    assign w_hex     = hex_decode(rx_data);
    assign w_eol     = is_eol(rx_data);
    assign w_is_s    = (rx_data == ASC_S_UP) || (rx_data == ASC_S_LO);
    assign w_chan_ok = (rx_data >= ASC_0) && (rx_data < CH_LIMIT);
    assign w_digit   = rx_data - ASC_0;
    assign w_tmr_en  = (r_state != ST_IDLE);
    // A byte in the expiry cycle wins over the timeout
    assign w_timeout = w_expired && !rx_avail && (r_state != ST_IDLE);

    uart_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (rx_avail),
        .i_en     (w_tmr_en),
        .o_expired(w_expired)
    );

    // State register and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_chan_tmp  <= '0;
            r_value     <= '0;
            r_nib_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_chan  <= '0;
            r_cmd_value <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_valid <= w_valid_next;
            r_cmd_err   <= w_err_next;
            if (w_chan_ld) begin
                r_chan_tmp <= w_digit[CH_W-1:0];
                r_nib_cnt  <= '0;
                r_value    <= '0;
            end
            if (w_nib_ld) begin
                r_value   <= {r_value[11:0], w_hex.nib};
                r_nib_cnt <= r_nib_cnt + 2'd1;
            end
            if (w_valid_next) begin
                r_cmd_chan  <= r_chan_tmp;
                r_cmd_value <= r_value;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (rx_avail) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_s)
                        w_state_next = ST_CHAN;
                    else if (!(w_eol || rx_data == ASC_SP))
                        w_state_next = ST_SKIP;
                end
                ST_CHAN: begin
                    if (w_chan_ok)  w_state_next = ST_HEX;
                    else if (w_eol) w_state_next = ST_IDLE;
                    else            w_state_next = ST_SKIP;
                end
                ST_HEX: begin
                    if (w_hex.ok)   w_state_next = (r_nib_cnt == 2'd3) ? ST_TERM : ST_HEX;
                    else if (w_eol) w_state_next = ST_IDLE;
                    else            w_state_next = ST_SKIP;
                end
                ST_TERM: begin
                    w_state_next = w_eol ? ST_IDLE : ST_SKIP;
                end
                ST_SKIP: begin
                    if (w_eol) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = ST_IDLE;
        end
    end

    // Output / load-enable logic
    always_comb begin
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_chan_ld    = 1'b0;
        w_nib_ld     = 1'b0;
        if (rx_avail) begin
            case (r_state)
                ST_IDLE: w_err_next = !(w_is_s || w_eol || rx_data == ASC_SP);
                ST_CHAN: begin
                    w_chan_ld  = w_chan_ok;
                    w_err_next = !w_chan_ok;
                end
                ST_HEX: begin
                    w_nib_ld   = w_hex.ok;
                    w_err_next = !w_hex.ok;
                end
                ST_TERM: begin
                    w_valid_next = w_eol;
                    w_err_next   = !w_eol;
                end
                default: ;
            endcase
        end else if (w_timeout && (r_state != ST_SKIP)) begin
            // an abandoned line that was already rejected times out silently
            w_err_next = 1'b1;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_err   = r_cmd_err;
    assign cmd_chan  = r_cmd_chan;
    assign cmd_value = r_cmd_value;
    assign busy      = (r_state != ST_IDLE);

`ifdef UART_CMD_ACK_EN
    logic       r_ack_valid;
    logic [7:0] r_ack_data;
    logic       w_keep_e;

    // A pending 'E' that is not being taken this cycle is not replaced by 'K'
    assign w_keep_e = r_ack_valid && !ack_ready && (r_ack_data == ASC_E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_valid <= 1'b0;
            r_ack_data  <= '0;
        end else if (r_cmd_err) begin
            r_ack_valid <= 1'b1;
            r_ack_data  <= ASC_E;
        end else if (r_cmd_valid && !w_keep_e) begin
            r_ack_valid <= 1'b1;
            r_ack_data  <= ASC_K;
        end else if (ack_ready) begin
            r_ack_valid <= 1'b0;
        end
    end

    assign ack_valid = r_ack_valid;
    assign ack_data  = r_ack_data;
`endif

endmodule
